// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the line-transfer DRAM controller.
//   state_e    : controller FSM states (idle / word access / response).
//   AddrW      : DRAM byte-address width.
//   WordW      : DRAM word width; line word k lives in bits [k*WordW +: WordW].
//   WordBytes  : bytes per DRAM word.
//   line_base(): aligns a byte address down to the start of its line.

// Fallback values for builds that do not pull in the shared config include first.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 16
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

package dram_ctrl_pkg;

  localparam int unsigned AddrW     = `DRAM_ADDRESS_SIZE;
  localparam int unsigned WordW     = `DRAM_WORD_SIZE;
  localparam int unsigned WordBytes = WordW / 8;

  // StIdle = IDLE, StAccess = ACCESS, StResp = RESP.
  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // Clears the low log2(line_words*WordBytes) bits; line_words is a power of two.
  function automatic logic [AddrW-1:0] line_base(input logic [AddrW-1:0] addr,
                                                 input int unsigned      line_words);
    logic [AddrW-1:0] mask;
    mask = AddrW'(line_words * WordBytes - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// Requester-side handshake bundle for dram_ctrl.
//   req_valid/req_ready   : request handshake (line read or write).
//   req_write, req_addr   : direction and byte address of the line.
//   req_wdata             : write line, word k in bits [k*WordW +: WordW].
//   resp_valid/resp_ready : completion handshake.
//   resp_rdata            : read line, same packing as req_wdata.
// Modports: master = requester, slave = controller.

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 16
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

interface dram_ctrl_if #(
  parameter int unsigned LINE_WORDS = 4
) ();

  logic                                  req_valid;
  logic                                  req_ready;
  logic                                  req_write;
  logic [`DRAM_ADDRESS_SIZE-1:0]         req_addr;
  logic [LINE_WORDS*`DRAM_WORD_SIZE-1:0] req_wdata;
  logic                                  resp_valid;
  logic                                  resp_ready;
  logic [LINE_WORDS*`DRAM_WORD_SIZE-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/dram_ctrl.sv
// Line-transfer DRAM controller. Accepts one line request at a time, walks the line one
// word per WAIT_CYCLES cycles on a shared bidirectional DRAM bus, then holds a response
// until the requester takes it.
//   clock, reset  : single clock, synchronous active-high reset.
//   host          : request/response handshake (dram_ctrl_if.slave).
//   dram_address  : byte address of the word currently on the bus (wraps at top of memory).
//   dram_wren     : registered write enable; also the only enable of the data driver.
//   dram_data     : shared little-endian data bus, driven only while dram_wren is 1.

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 16
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned LINE_WORDS  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  dram_ctrl_if.slave                    host,
  output logic [`DRAM_ADDRESS_SIZE-1:0] dram_address,
  output logic                          dram_wren,
  inout  wire  [`DRAM_WORD_SIZE-1:0]    dram_data
);

  localparam int unsigned LineW = LINE_WORDS * WordW;
  localparam int unsigned CntW  = 4;
  localparam logic [CntW-1:0] LastWait = CntW'(WAIT_CYCLES - 1);
  localparam logic [CntW-1:0] LastWord = CntW'(LINE_WORDS - 1);

  state_e            state_q;
  logic [CntW-1:0]   word_q;
  logic [CntW-1:0]   wait_q;
  logic [CntW-1:0]   word_nxt;
  logic              write_q;
  logic [AddrW-1:0]  base_q;
  logic [AddrW-1:0]  addr_q;
  logic [LineW-1:0]  wdata_q;
  logic [LineW-1:0]  rdata_q;
  logic [WordW-1:0]  dout_q;
  logic              wren_q;
  logic              req_ready_q;
  logic              resp_valid_q;

  assign word_nxt = word_q + CntW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      word_q       <= '0;
      wait_q       <= '0;
      write_q      <= 1'b0;
      base_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      dout_q       <= '0;
      wren_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (host.req_valid && req_ready_q) begin
            write_q     <= host.req_write;
            base_q      <= line_base(host.req_addr, LINE_WORDS);
            addr_q      <= line_base(host.req_addr, LINE_WORDS);
            wdata_q     <= host.req_wdata;
            dout_q      <= host.req_wdata[WordW-1:0];
            wren_q      <= host.req_write;
            word_q      <= '0;
            wait_q      <= '0;
            req_ready_q <= 1'b0;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (wait_q == LastWait) begin
            wait_q <= '0;
            // Last hold cycle of this word: the DRAM read data has had the full hold time.
            if (!write_q) begin
              rdata_q[word_q*WordW +: WordW] <= dram_data;
            end
            if (word_q == LastWord) begin
              word_q       <= '0;
              wren_q       <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              // Address and write word advance together so the bus presents a coherent pair.
              word_q <= word_nxt;
              addr_q <= base_q + AddrW'(word_nxt * WordBytes);
              dout_q <= wdata_q[word_nxt*WordW +: WordW];
            end
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        StResp: begin
          if (host.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign host.req_ready  = req_ready_q;
  assign host.resp_valid = resp_valid_q;
  assign host.resp_rdata = rdata_q;
  assign dram_address    = addr_q;
  assign dram_wren       = wren_q;

  // Driver enable is the same flop that is exported as dram_wren.
  assign dram_data = wren_q ? dout_q : 'z;

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl (WAIT_CYCLES=2, LINE_WORDS=4) with a byte-array DRAM.
// Stimulus pushes expected responses and expected write-bus cycles into queues; negedge
// monitors pop and compare whenever the DUT presents a response or drives a write.

module tb_dram_ctrl;
  import dram_ctrl_pkg::*;

  localparam int unsigned WC        = 2;
  localparam int unsigned LW        = 4;
  localparam int unsigned LineW     = LW * WordW;
  localparam int unsigned LineBytes = LW * WordBytes;
  localparam int unsigned MemSize   = 1 << AddrW;

  typedef logic [LineW-1:0] line_t;
  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [WordW-1:0] data;
  } bus_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [AddrW-1:0] dram_address;
  logic             dram_wren;
  wire  [WordW-1:0] dram_data;

  dram_ctrl_if #(.LINE_WORDS(LW)) bif ();

  dram_ctrl #(
    .WAIT_CYCLES(WC),
    .LINE_WORDS (LW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .host        (bif),
    .dram_address(dram_address),
    .dram_wren   (dram_wren),
    .dram_data   (dram_data)
  );

  // DRAM array: asynchronous read onto the bus when not writing, byte writes at the edge.
  logic [7:0]       dmem [0:MemSize-1];
  logic [WordW-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < WordBytes; i++) begin
      rd_word[8*i +: 8] = dmem[AddrW'(dram_address + AddrW'(i))];
    end
  end

  assign dram_data = dram_wren ? 'z : rd_word;

  always @(posedge clock) begin
    if (dram_wren) begin
      for (int i = 0; i < WordBytes; i++) begin
        dmem[AddrW'(dram_address + AddrW'(i))] = dram_data[8*i +: 8];
      end
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [0:MemSize-1];
  line_t      last_rdata;
  line_t      resp_q[$];
  bus_t       bus_q[$];
  bus_t       bus_e;
  int         tests = 0;
  int         fails = 0;

  task automatic check_line(input string name, input line_t act, input line_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < LW; k++) l[k*WordW +: WordW] = WordW'($urandom);
    return l;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Response scoreboard and write-bus monitor.
  always @(negedge clock) begin
    if (!reset && bif.resp_valid && bif.resp_ready) begin
      if (resp_q.size() == 0) fail_now("unexpected_resp");
      else check_line("resp_rdata", bif.resp_rdata, resp_q.pop_front());
    end
    if (dram_wren) begin
      if (bus_q.size() == 0) begin
        fail_now("unexpected_wren");
      end else begin
        bus_e = bus_q.pop_front();
        check_line("bus_addr", line_t'(dram_address), line_t'(bus_e.addr));
        check_line("bus_data", line_t'(dram_data), line_t'(bus_e.data));
      end
    end else if (!reset) begin
      check_line("bus_read_data", line_t'(dram_data), line_t'(rd_word));
    end
  end

  // Record expectations for an accepted request (line-level behaviour).
  task automatic expect_req(input logic wr, input logic [AddrW-1:0] addr, input line_t wd);
    logic [AddrW-1:0] base;
    line_t            exp;
    base = addr & ~AddrW'(LineBytes - 1);
    if (wr) begin
      for (int k = 0; k < LW; k++) begin
        for (int b = 0; b < WordBytes; b++) begin
          ref_mem[AddrW'(base + AddrW'(k*WordBytes + b))] = wd[k*WordW + 8*b +: 8];
        end
        for (int c = 0; c < WC; c++) begin
          bus_q.push_back('{addr: AddrW'(base + AddrW'(k*WordBytes)), data: wd[k*WordW +: WordW]});
        end
      end
      resp_q.push_back(last_rdata);
    end else begin
      exp = '0;
      for (int i = 0; i < LineBytes; i++) exp[8*i +: 8] = ref_mem[AddrW'(base + AddrW'(i))];
      resp_q.push_back(exp);
      last_rdata = exp;
    end
  endtask

  task automatic do_req(input logic wr, input logic [AddrW-1:0] addr, input line_t wd,
                        input int hold);
    int    n;
    line_t r0;
    bif.req_valid = 1'b1;
    bif.req_write = wr;
    bif.req_addr  = addr;
    bif.req_wdata = wd;
    n = 0;
    while (!bif.req_ready) begin
      if (n == 50) begin
        fail_now("accept_timeout");
        bif.req_valid = 1'b0;
        return;
      end
      step();
      n++;
    end
    expect_req(wr, addr, wd);
    step();
    // Garbage on the request side while busy must be ignored.
    bif.req_valid = 1'b0;
    bif.req_write = 1'($urandom);
    bif.req_addr  = AddrW'($urandom);
    bif.req_wdata = rand_line();
    n = 0;
    while (!bif.resp_valid && n < 100) begin
      step();
      n++;
    end
    if (!bif.resp_valid) begin
      fail_now("resp_timeout");
      return;
    end
    check_int("latency", n, LW * WC);
    r0 = bif.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      step();
      check_bit("hold_valid", bif.resp_valid, 1'b1);
      check_line("hold_rdata", bif.resp_rdata, r0);
      check_bit("hold_req_ready", bif.req_ready, 1'b0);
    end
    check_bit("hs_req_ready", bif.req_ready, 1'b0);
    bif.resp_ready = 1'b1;
    step();
    bif.resp_ready = 1'b0;
    check_bit("post_hs_valid", bif.resp_valid, 1'b0);
    check_bit("post_hs_req_ready", bif.req_ready, 1'b1);
  endtask

  task automatic abort_test();
    logic seen;
    line_t wd;
    wd = rand_line();
    bif.req_valid = 1'b1;
    bif.req_write = 1'b1;
    bif.req_addr  = AddrW'(16'h3004);
    bif.req_wdata = wd;
    check_bit("abort_pre_ready", bif.req_ready, 1'b1);
    for (int k = 0; k < LW; k++) begin
      for (int c = 0; c < WC; c++) begin
        bus_q.push_back('{addr: AddrW'(16'h3000 + k*WordBytes), data: wd[k*WordW +: WordW]});
      end
    end
    step();
    bif.req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_bit("abort_wren", dram_wren, 1'b0);
    check_bit("abort_req_ready", bif.req_ready, 1'b1);
    check_bit("abort_resp_valid", bif.resp_valid, 1'b0);
    check_int("abort_bus_cycles", bus_q.size(), LW * WC - 3);
    bus_q.delete();
    last_rdata = '0;
    bif.resp_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (bif.resp_valid || dram_wren) seen = 1'b1;
    end
    bif.resp_ready = 1'b0;
    check_bit("abort_quiet", seen, 1'b0);
  endtask

  initial begin
    line_t            wline;
    logic [7:0]       b;
    logic             wr;
    logic [AddrW-1:0] addr;

    for (int i = 0; i < MemSize; i++) begin
      b          = 8'($urandom);
      dmem[i]    = b;
      ref_mem[i] = b;
    end
    last_rdata     = '0;
    bif.req_valid  = 1'b0;
    bif.req_write  = 1'b0;
    bif.req_addr   = '0;
    bif.req_wdata  = '0;
    bif.resp_ready = 1'b0;

    step();
    step();
    reset = 1'b0;
    check_bit("rst_req_ready", bif.req_ready, 1'b1);
    check_bit("rst_resp_valid", bif.resp_valid, 1'b0);
    check_bit("rst_wren", dram_wren, 1'b0);
    check_line("rst_address", line_t'(dram_address), '0);
    check_line("rst_rdata", bif.resp_rdata, '0);

    // Line write at 0x40, then byte-level little-endian layout in the array.
    wline = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    do_req(1'b1, AddrW'(16'h0040), wline, 0);
    for (int i = 0; i < 16; i++) begin
      check_int("mem_byte", int'(dmem[16'h0040 + i]), (i / 4 + 1) * 'h11);
    end

    // Unaligned read returns the aligned line just written.
    do_req(1'b0, AddrW'(16'h0048), '0, 0);
    check_line("read_back_line", bif.resp_rdata, wline);

    // Response held off by the requester for 5 cycles.
    do_req(1'b0, AddrW'(16'h0040), '0, 5);

    // Top line of memory, then read it back.
    do_req(1'b1, AddrW'(16'hFFF7), rand_line(), 1);
    do_req(1'b0, AddrW'(16'hFFF0), '0, 0);

    // Back-to-back write then read over the bus turnaround.
    do_req(1'b1, AddrW'(16'h0200), rand_line(), 0);
    do_req(1'b0, AddrW'(16'h0204), '0, 0);

    abort_test();

    // Reset clears resp_rdata, so a write right after must report zeros.
    do_req(1'b1, AddrW'(16'h0300), rand_line(), 0);
    check_line("rdata_after_reset", bif.resp_rdata, '0);

    repeat (40) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) addr = AddrW'(16'hFFE0 + $urandom_range(0, 31));
      else addr = AddrW'(16'h1000 + $urandom_range(0, 255));
      do_req(wr, addr, rand_line(), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
    end

    repeat (4) step();
    check_int("resp_queue_drained", resp_q.size(), 0);
    check_int("bus_queue_drained", bus_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 The parameter list SHALL be: WAIT_CYCLES, default 2, number of clock cycles each word access is held on the DRAM bus (legal values 1..15).
REQ-002 The parameter list SHALL continue: LINE_WORDS, default 4, words per line transfer (power of two, 1..8).
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  requester presents a line request.
REQ-006 Port: req_ready  output  1  controller can accept a request.
REQ-007 Port: req_write  input  1  1 = line write, 0 = line read.
REQ-008 Port: req_addr  input  `DRAM_ADDRESS_SIZE  byte address of the line.
REQ-009 Port: req_wdata  input  LINE_WORDS*`DRAM_WORD_SIZE  write line; word k is in bits [k*32 +: 32].
REQ-010 Port: resp_valid  output  1  request complete (read data valid).
REQ-011 Port: resp_ready  input  1  requester accepts the response.
REQ-012 Port: resp_rdata  output  LINE_WORDS*`DRAM_WORD_SIZE  read line, same packing as req_wdata.
REQ-013 Port: dram_address  output  `DRAM_ADDRESS_SIZE  byte address to the DRAM array.
REQ-014 Port: dram_wren  output  1  DRAM write enable.
REQ-015 Port: dram_data  inout  `DRAM_WORD_SIZE  shared bidirectional little-endian data bus.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 On req_valid && req_ready, the controller SHALL latch write flag, address and wdata, then enter ACCESS; word counter = 0 and wait counter = 0.
REQ-018 The latched line base SHALL be req_addr with its low log2(LINE_WORDS*4) bits forced to 0.
REQ-019 In ACCESS, dram_address SHALL equal base + 4*word counter, computed modulo 2**`DRAM_ADDRESS_SIZE (wrap-around at the top of memory).
REQ-020 Each word SHALL be held for exactly WAIT_CYCLES cycles; the wait counter then clears and the word counter increments.
REQ-021 For writes, dram_wren SHALL be 1 throughout ACCESS, and dram_data SHALL be driven with latched word k.
REQ-022 For reads, dram_wren SHALL be 0, and dram_data SHALL be high-Z from the controller.
REQ-023 For reads, the controller SHALL capture word k from dram_data into resp_rdata on the last cycle of that word's hold.
REQ-024 dram_data SHALL be driven only when a registered dram_wren is 1, and both SHALL come from the same register, so the bus is never contended.
REQ-025 After the last word's final cycle, the FSM SHALL enter RESP; ACCESS therefore lasts exactly LINE_WORDS*WAIT_CYCLES cycles.
REQ-026 In RESP, resp_valid SHALL be 1 and stay stable, with resp_rdata stable, until resp_ready is 1; the FSM then returns to IDLE.
REQ-027 A new request SHALL NOT be accepted in the cycle the response handshakes; the earliest acceptance is the following cycle.
REQ-028 For writes, resp_valid SHALL signal completion and resp_rdata SHALL hold its previous value.
REQ-029 In IDLE and RESP, dram_wren SHALL be 0 and dram_address SHALL hold its last value.
REQ-030 req_* changes while not in IDLE SHALL have no effect.

Reset
REQ-031 With reset = 1 at a rising edge, the state SHALL become IDLE, counters 0, dram_wren 0, dram_address 0, resp_valid 0 and resp_rdata 0; req_ready SHALL be 1 after the edge.
REQ-032 Reset mid-ACCESS or mid-RESP SHALL abort the transfer with no response, and dram_wren SHALL be 0 from the next cycle.

Structure
REQ-033 Package dram_ctrl_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and the line packing helper constants.
REQ-034 The address and word-size macros SHALL come from the shared config/constants includes.
REQ-035 No sub-module is required; the bus tri-state SHALL be a single continuous assignment.

Verification (bench instantiates dram_ctrl with the DRAM array, WAIT_CYCLES=2, LINE_WORDS=4)
REQ-036 Write line 0x40 = {0x44444444, 0x33333333, 0x22222222, 0x11111111} -> resp_valid 8 cycles after acceptance, and memory bytes 0x40..0x4F match little-endian.
REQ-037 Read of 0x48 after REQ-036 -> base 0x40, and resp_rdata matches the written line exactly.
REQ-038 Read with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable; req_ready 0 until one cycle after the handshake.
REQ-039 Write at the top line (base = 2**`DRAM_ADDRESS_SIZE - 16) -> addresses cover the last 16 bytes with no overflow beyond the memory.
REQ-040 Assert reset in the 3rd ACCESS cycle of a write -> no resp_valid, dram_wren 0 next cycle, req_ready 1 after reset.
REQ-041 Back-to-back write then read -> no cycle with both sides driving dram_data (no X on the bus during turnaround).
